fetch_stage: RTL

Fetch front-end of the 5-stage MIPS pipeline. It owns the architectural F_PC register and the F/D pipeline register, and it drives a variable-latency instruction-memory request/ready handshake. It consumes next_PC from the NPC block and feeds D_PC and D_instr to the decode stage, including the NPC/CMP logic. Branch delay slots are architectural, so the block never flushes. The only front-end hold sources are the hazard-unit stall and its own fetch_busy.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch front-end: F_PC, F/D register, variable-latency imem handshake
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_PC,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_exc_adel,
    output logic        fetch_busy
);

    // Upper bound of the legal window, one bit wider so base+size cannot wrap.
    localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    logic [31:0]  hold_buf;
    logic         bad_addr;
    logic         transfer;
    logic [31:0]  word;

    // Address error: misaligned or outside the instruction window.
    always_comb begin
        bad_addr = (F_PC[1:0] != 2'b00)
                 | (F_PC < IMEM_BASE)
                 | ({1'b0, F_PC} >= IMEM_END);
    end

    // Handshake, hold indication, transfer decision and word selection.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = F_PC;
        fetch_busy = 1'b0;
        transfer   = 1'b0;
        word       = 32'h0000_0000;
        case (state)
            IDLE: begin
                fetch_busy = 1'b1;
            end
            REQ: begin
                if (bad_addr) begin
                    // Faulting fetch completes at once without touching memory.
                    transfer = !stall;
                    word     = 32'h0000_0000;
                end else begin
                    imem_req   = 1'b1;
                    fetch_busy = !imem_ready;
                    transfer   = imem_ready && !stall;
                    word       = imem_rdata;
                end
            end
            HOLD: begin
                transfer = !stall;
                word     = hold_buf;
            end
            default: begin
                fetch_busy = 1'b1;
            end
        endcase
    end

    // Fetch FSM, hold buffer, F_PC and the F/D pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_buf   <= 32'h0000_0000;
            F_PC       <= PC_RESET;
            D_PC       <= 32'h0000_0000;
            D_instr    <= 32'h0000_0000;
            D_valid    <= 1'b0;
            D_exc_adel <= 1'b0;
        end else begin
            if (transfer) begin
                F_PC       <= next_PC;
                D_PC       <= F_PC;
                D_instr    <= word;
                D_valid    <= 1'b1;
                D_exc_adel <= bad_addr;
            end
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // Word arrived while decode is held: park it until stall drops.
                    if (!bad_addr && imem_ready && stall) begin
                        hold_buf <= imem_rdata;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
